// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: load/stage/butterfly sequencer with address and twiddle generation for a radix-2 DIF FFT
module fft_stage_sequencer #(
    parameter int D_WIDTH     = 64,
    parameter int LOG_2_WIDTH = 6,
    parameter int BF_LATENCY  = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           load_en,
    output logic                           bf_valid,
    output logic [LOG_2_WIDTH-1:0]         addr_a,
    output logic [LOG_2_WIDTH-1:0]         addr_b,
    output logic [LOG_2_WIDTH-2:0]         tw_idx,
    output logic [$clog2(LOG_2_WIDTH)-1:0] stage,
    output logic                           done
);
    localparam int SW = $clog2(LOG_2_WIDTH);
    localparam int KW = LOG_2_WIDTH - 1;
    localparam int DW = BF_LATENCY > 1 ? $clog2(BF_LATENCY) : 1;
    localparam logic [SW-1:0] S_LAST = SW'(LOG_2_WIDTH - 1);
    localparam logic [KW-1:0] K_LAST = KW'(D_WIDTH / 2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(BF_LATENCY > 0 ? BF_LATENCY - 1 : 0);
    localparam logic [LOG_2_WIDTH-1:0] HALF0 = LOG_2_WIDTH'(D_WIDTH / 2);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
    state_t state, state_n;
    logic [SW-1:0] s, s_n;
    logic [KW-1:0] k, k_n;
    logic [DW-1:0] d, d_n;
    logic [LOG_2_WIDTH-1:0] half, mask, kx, a_n;
    logic [KW-1:0] t_n;
    logic next_stage;

    // Outputs are registered from the next state, so they line up with the state they describe.
    always_comb begin
        state_n = state;
        s_n = s;
        k_n = k;
        d_n = d;
        next_stage = 1'b0;
        case (state)
            IDLE: state_n = start ? LOAD : IDLE;
            LOAD: begin
                state_n = RUN;
                s_n = '0;
                k_n = '0;
            end
            RUN: begin
                k_n = k + 1'b1;
                if (k == K_LAST) begin
                    d_n = '0;
                    if (BF_LATENCY > 0) state_n = DRAIN;
                    else next_stage = 1'b1;
                end
            end
            DRAIN: begin
                d_n = d + 1'b1;
                next_stage = d == D_LAST;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (next_stage) begin
            state_n = s == S_LAST ? DONE : RUN;
            s_n = s == S_LAST ? s : s + 1'b1;
            k_n = '0;
        end
        half = HALF0 >> s_n;
        mask = half - 1'b1;
        kx = {1'b0, k_n};
        a_n = ((kx & ~mask) << 1) | (kx & mask);
        t_n = KW'((kx & mask) << s_n);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            s <= '0;
            k <= '0;
            d <= '0;
            busy <= 1'b0;
            load_en <= 1'b0;
            bf_valid <= 1'b0;
            done <= 1'b0;
            addr_a <= '0;
            addr_b <= '0;
            tw_idx <= '0;
            stage <= '0;
        end else begin
            state <= state_n;
            s <= s_n;
            k <= k_n;
            d <= d_n;
            busy <= state_n != IDLE;
            load_en <= state_n == LOAD;
            bf_valid <= state_n == RUN;
            done <= state_n == DONE;
            addr_a <= state_n == RUN ? a_n : '0;
            addr_b <= state_n == RUN ? a_n | half : '0;
            tw_idx <= state_n == RUN ? t_n : '0;
            stage <= state_n == RUN ? s_n : '0;
        end
    end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of a 64-point sequencer and a 16-point zero-latency build
module tb_fft_stage_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic start2 = 1'b0;
    logic busy, load_en, bf_valid, done;
    logic [5:0] addr_a, addr_b;
    logic [4:0] tw_idx;
    logic [2:0] stage;
    logic busy2, load_en2, bf_valid2, done2;
    logic [3:0] addr_a2, addr_b2;
    logic [2:0] tw_idx2;
    logic [1:0] stage2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .load_en(load_en),
        .bf_valid(bf_valid), .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
        .stage(stage), .done(done)
    );

    fft_stage_sequencer #(.D_WIDTH(16), .LOG_2_WIDTH(4), .BF_LATENCY(0)) u_small (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .load_en(load_en2),
        .bf_valid(bf_valid2), .addr_a(addr_a2), .addr_b(addr_b2), .tw_idx(tw_idx2),
        .stage(stage2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {busy, load_en, bf_valid, done, stage, addr_a, addr_b, tw_idx};
    endfunction

    task automatic full_run(input bit poke);
        int bfc, gap, done_at, dones, loads, dup, cov;
        logic [63:0] seen [6];
        bfc = 0; gap = 0; done_at = -1; dones = 0; loads = 0; dup = 0; cov = 0;
        for (int i = 0; i < 6; i++) seen[i] = '0;
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        for (int cyc = 1; cyc <= 210; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk);
                #1;
            end
            if (bf_valid && stage < 3'd6) begin
                bfc++;
                if (seen[stage][addr_a]) dup++;
                seen[stage][addr_a] = 1'b1;
                if (seen[stage][addr_b]) dup++;
                seen[stage][addr_b] = 1'b1;
            end
            if (busy && !bf_valid && !load_en && !done) gap++;
            if (load_en) loads++;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = cyc;
            end
            if (cyc == 1) check("load_cycle", {busy, load_en, bf_valid}, 3'b110);
            if (cyc == 2) check("s0_k0", {stage, addr_a, addr_b, tw_idx}, {3'd0, 6'd0, 6'd32, 5'd0});
            if (cyc == 33) check("s0_k31", {stage, addr_a, addr_b, tw_idx}, {3'd0, 6'd31, 6'd63, 5'd31});
            if (cyc == 34) check("drain_gap", {busy, bf_valid, addr_a, addr_b}, {1'b1, 1'b0, 12'd0});
            if (cyc == 52) check("s1_k16", {stage, addr_a, addr_b, tw_idx}, {3'd1, 6'd32, 6'd48, 5'd0});
            if (cyc == 53) check("s1_k17", {stage, addr_a, addr_b, tw_idx}, {3'd1, 6'd33, 6'd49, 5'd2});
            if (cyc == 172) check("s5_k0", {stage, addr_a, addr_b, tw_idx}, {3'd5, 6'd0, 6'd1, 5'd0});
            if (cyc == 182) check("s5_k10", {stage, addr_a, addr_b, tw_idx}, {3'd5, 6'd20, 6'd21, 5'd0});
            if (cyc == 203) check("s5_k31", {stage, addr_a, addr_b, tw_idx}, {3'd5, 6'd62, 6'd63, 5'd0});
            if (cyc == 207) check("idle_after_done", {busy, load_en}, 2'b00);
            if (cyc == 208) check("no_queued_start", {busy, load_en}, 2'b00);
            start = poke && (cyc == 50 || cyc == 206);
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) if (&seen[i]) cov++;
        check("bf_valid_count", bfc, 192);
        check("done_cycle", done_at, 206);
        check("done_pulses", dones, 1);
        check("load_pulses", loads, 1);
        check("gap_cycles", gap, 12);
        check("dup_index", dup, 0);
        check("stage_coverage", cov, 6);
    endtask

    initial begin
        int act;
        int dones;
        repeat (2) @(posedge clk);
        #1 check("reset_outputs", all_out(), 0);
        @(negedge clk) rst = 1'b0;
        act = 0;
        repeat (20) begin
            @(posedge clk);
            #1 act += int'(busy | load_en | bf_valid | done);
        end
        check("idle_quiet", act, 0);

        full_run(1'b1);

        // start held high: restart on the first IDLE cycle after DONE
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 208; cyc++) begin
            if (cyc > 1) @(posedge clk);
            #1;
            if (cyc == 206) check("held_done", done, 1'b1);
            if (cyc == 207) check("held_idle", busy, 1'b0);
            if (cyc == 208) check("held_restart", load_en, 1'b1);
        end
        start = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;

        // abort in stage 2 RUN
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        for (int cyc = 2; cyc <= 100; cyc++) begin
            @(posedge clk);
            #1;
        end
        check("pre_abort", {bf_valid, stage}, {1'b1, 3'd2});
        #2 rst = 1'b1;
        #1 check("abort_outputs", all_out(), 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        act = 0;
        dones = 0;
        repeat (250) begin
            @(posedge clk);
            #1;
            act += int'(busy);
            dones += int'(done);
        end
        check("abort_no_busy", act, 0);
        check("abort_no_done", dones, 0);
        full_run(1'b0);

        // 16-point, zero drain latency
        begin
            int bfc, gap, done_at;
            bfc = 0; gap = 0; done_at = -1;
            @(negedge clk) start2 = 1'b1;
            @(posedge clk) #1 start2 = 1'b0;
            for (int cyc = 1; cyc <= 40; cyc++) begin
                if (cyc > 1) begin
                    @(posedge clk);
                    #1;
                end
                if (bf_valid2) bfc++;
                if (busy2 && !bf_valid2 && !load_en2 && !done2) gap++;
                if (done2 && done_at < 0) done_at = cyc;
                if (cyc == 2) check("sm_s0_k0", {stage2, addr_a2, addr_b2, tw_idx2}, {2'd0, 4'd0, 4'd8, 3'd0});
                if (cyc == 15) check("sm_s1_k5", {stage2, addr_a2, addr_b2, tw_idx2}, {2'd1, 4'd9, 4'd13, 3'd2});
                if (cyc == 29) check("sm_s3_k3", {stage2, addr_a2, addr_b2, tw_idx2}, {2'd3, 4'd6, 4'd7, 3'd0});
                if (cyc == 33) check("sm_s3_k7", {stage2, addr_a2, addr_b2, tw_idx2}, {2'd3, 4'd14, 4'd15, 3'd0});
            end
            check("sm_bf_count", bfc, 32);
            check("sm_gap", gap, 0);
            check("sm_done_cycle", done_at, 34);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Control FSM for the 64-point radix-2 DIF FFT datapath.
- On start, it pulses the input signal router load, then steps through LOG_2_WIDTH stages of D_WIDTH/2 butterflies each.
- Each cycle it issues the butterfly operand address pair, twiddle factor index and stage number to the butterfly unit. It inserts drain gaps for the butterfly pipeline and signals completion.
- It replaces the ad hoc CountTo64 / StageClock / TwiddleFactorIndex counters with one sequencer.

Parameters:
- D_WIDTH, 64, number of FFT points; power of two, at least 4.
- LOG_2_WIDTH, 6, log2(D_WIDTH) = number of stages.
- BF_LATENCY, 2, butterfly pipeline depth in cycles; idle gap inserted after each stage; 0 is legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; asynchronous, active-high.
- start  in  1  request a transform; sampled only in IDLE.
- busy  out  1  high from LOAD through DONE inclusive.
- load_en  out  1  one-cycle pulse: router captures input_sig_Re/Im.
- bf_valid  out  1  addr_a/addr_b/tw_idx/stage are valid this cycle.
- addr_a  out  LOG_2_WIDTH  upper butterfly operand index.
- addr_b  out  LOG_2_WIDTH  lower butterfly operand index.
- tw_idx  out  LOG_2_WIDTH-1  twiddle ROM index.
- stage  out  $clog2(LOG_2_WIDTH)  current stage, 0-based.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset, asynchronous and active-high: state goes to IDLE; stage and butterfly counters and drain counter clear. All outputs are 0 while rst is high and in the first cycle after release.
- All outputs are decoded from registered state and counters only. No combinational path from start to any output.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
  - IDLE: start=1 at an edge -> LOAD. Otherwise stay.
  - LOAD: one cycle, load_en=1. Clear s=0, k=0. -> RUN.
  - RUN: bf_valid=1. Increment k each cycle. When k=D_WIDTH/2-1: if BF_LATENCY>0 -> DRAIN, else take the next-stage decision directly.
  - DRAIN: bf_valid=0 for exactly BF_LATENCY cycles. Then take the next-stage decision.
  - Next-stage decision: if s=LOG_2_WIDTH-1 -> DONE; else s++, k=0 -> RUN.
  - DONE: one cycle, done=1, busy=1. -> IDLE.
- Address generation for stage s, butterfly k (0..D_WIDTH/2-1):
  - half = D_WIDTH >> (s+1).
  - addr_a = (k / half)*2*half + (k mod half).
  - addr_b = addr_a + half.
  - tw_idx = (k mod half) << s, truncated to LOG_2_WIDTH-1 bits.
  - Implement with shifts and masks, no dividers.
- Addresses are 0 whenever bf_valid=0.
- Timing, with the LOAD cycle as cycle 1 and default parameters:
  - Stage s RUN occupies cycles 2+34s .. 33+34s.
  - DONE is cycle 206.
  - In general, DONE occurs 1 + LOG_2_WIDTH*(D_WIDTH/2+BF_LATENCY) cycles after LOAD.
- start while busy, including in the DONE cycle, is ignored and not queued. A start held high continuously restarts on the first IDLE cycle after DONE.
- rst asserted mid-transform: immediate return to IDLE, outputs 0. No done pulse is issued for the aborted transform.

Test Plan:
- Reset then idle: hold rst 2 cycles, start=0 for 20 cycles -> busy, load_en, bf_valid and done stay 0.
- Full run, default parameters: start pulse -> load_en one cycle (cycle 1), then:
  - cycle 2: stage=0, (a,b,tw)=(0,32,0); cycle 33: (31,63,31).
  - stage 1, k=16: (a,b,tw)=(32,48,0); k=17: (33,49,2).
  - stage 5, k=k: (2k, 2k+1, 0).
  - done exactly at cycle 206; exactly 192 bf_valid cycles in total.
- Coverage check: per stage, every index 0..63 appears exactly once across addr_a and addr_b. Gap between stages is exactly BF_LATENCY cycles with bf_valid=0.
- start during busy (cycles 50 and 206) -> no effect. Next transform starts only on a start sampled in IDLE.
- rst pulse at cycle 100 (stage 2 RUN) -> outputs 0 immediately. No done pulse. A new start afterwards yields a clean full run.
- BF_LATENCY=0 and D_WIDTH=16/LOG_2_WIDTH=4 builds -> back-to-back stages with no gap. done at cycle 1+4*8+1=34. Stage 3 pairs are (2k, 2k+1).
